io_annul_scheduler: RTL
=======================

# io_annul_scheduler

Per-thread I/O retry scheduler for the Octavo barrel datapath. It sits after the datapath I/O predication stage and consumes its `IO_ready` verdict for the thread in the current pipeline slot. From that verdict it decides whether the instruction is annulled and re-issued or forced to complete, tracks consecutive retries per thread, and raises a sticky timeout when a thread starves on an I/O port.

## Interface
- `THREAD_COUNT`, 8: number of hardware threads in the barrel rotation; at least 2.
- `THREAD_WIDTH`, 3: width of thread index, equal to clog2(`THREAD_COUNT`).
- `RETRY_WIDTH`, 8: width of each per-thread consecutive-retry counter and of the limit.
- `STAT_WIDTH`, 16: width of the global annul statistics counter.

- `clock`, in, 1: single clock; all state on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `instr_valid`, in, 1: slot holds an instruction that accesses I/O (A/B read or write port).
- `IO_ready`, in, 1: predication verdict for this slot; 1 means all addressed ports are ready.
- `retry_limit`, in, `RETRY_WIDTH`: consecutive annuls allowed before timeout; 0 disables timeout.
- `clear_valid`, in, 1: strobe that clears the timeout state of `clear_thread`.
- `clear_thread`, in, `THREAD_WIDTH`: thread to clear.
- `current_thread`, out, `THREAD_WIDTH`: thread owning the current slot (registered).
- `annul`, out, 1: combinational; cancel the slot's writes and hold the thread's PC.
- `io_forced`, out, 1: combinational; the instruction completes despite `IO_ready`=0 because the thread is timed out.
- `timed_out`, out, `THREAD_COUNT`: sticky per-thread timeout flags (registered).
- `timeout_pulse`, out, 1: registered single-cycle pulse when a timeout is set.
- `timeout_thread`, out, `THREAD_WIDTH`: thread that raised the last timeout (registered, held).
- `retry_count`, out, `RETRY_WIDTH`: retry counter of `current_thread` (combinational read of registered state).
- `annul_total`, out, `STAT_WIDTH`: saturating count of all annuls since reset.

## Operation
- Thread counter: `current_thread` increments by 1 every cycle and wraps from `THREAD_COUNT`-1 to 0. There is no stall; the barrel never stops.
- Slot verdict, where t = `current_thread`:
  - `annul` = `instr_valid` & ~`IO_ready` & ~`timed_out[t]`.
  - `io_forced` = `instr_valid` & ~`IO_ready` & `timed_out[t]`.
  - If `instr_valid`=0 or `IO_ready`=1, both outputs are 0.
- `retry[t]` update at the clock edge:
  - On `annul`, `retry[t]` increments, saturating at all-ones.
  - On `instr_valid` & `IO_ready`, `retry[t]` is set to 0.
  - Otherwise, including on `io_forced`, it holds.
- Timeout: on an `annul` where `retry_limit`≠0 and `retry[t]`+1 ≥ `retry_limit`:
  - `timed_out[t]` is set.
  - `timeout_pulse` is 1 in the next cycle.
  - `timeout_thread` is set to t.
- A thread that is already timed out never re-pulses.
- Clear: `clear_valid` resets `timed_out[clear_thread]` and `retry[clear_thread]` to 0 at the edge.
- Simultaneous events:
  - Clear and timeout on the same thread in the same cycle: clear wins. No flag is set and no pulse fires.
  - Clear of a thread other than t and an annul/timeout of t: both take effect.
- `annul_total` increments on every `annul` and saturates at 2^`STAT_WIDTH`-1. `io_forced` does not count.
- Changing `retry_limit` mid-operation affects only future comparisons; existing flags are kept.

## Timing
- Reset values:
  - `current_thread`=0, all `retry`=0, `timed_out`=0.
  - `timeout_pulse`=0, `timeout_thread`=0, `annul_total`=0.
- Reset is asynchronous: every output listed above returns to its reset value immediately on assertion.
- `annul` and `io_forced` have zero latency: same cycle as `IO_ready`.
- State updates (`retry`, `timed_out`, `annul_total`) are visible one cycle after the edge. For thread t's counter, that is `THREAD_COUNT` cycles later on `retry_count`.
- `timeout_pulse` asserts exactly 1 cycle after the annulling slot and lasts 1 cycle.
- Reset deasserted mid-rotation: the rotation restarts at thread 0.

## Test plan
- Rotation: 20 cycles after reset release, with `instr_valid`=0 → `current_thread` reads 0,1,…,7,0,…; `annul`=0; `annul_total`=0.
- Retry then success: thread 3 gets `IO_ready`=0 for 3 rotations, then 1, with `retry_limit`=10 →
  - `annul`=1 on those 3 slots;
  - `retry_count` reads 1, 2, 3 on thread 3's next slots, then 0 after success;
  - `annul_total`=3.
- Timeout: `retry_limit`=4, thread 5 held not ready →
  - 4th annul sets `timed_out`=8'h20;
  - `timeout_pulse` is high one cycle later with `timeout_thread`=5;
  - next slot gives `annul`=0, `io_forced`=1, and no second pulse.
- Clear collision: `retry_limit`=2, thread 2 at `retry`=1 annulled while `clear_valid`=1 and `clear_thread`=2 → `timed_out[2]`=0, no pulse, `retry[2]`=0.
- Limit 0 and saturation: `retry_limit`=0 with thread 1 starved for 300 rotations → `retry_count` saturates at 255 and no timeout occurs. With `STAT_WIDTH`=4, `annul_total` stops at 15.
- Async reset mid-operation: assert `reset_n`=0 between edges while `timed_out`≠0 → all outputs are 0 immediately, before the next edge.

Source files
------------

// File: rtl/io_annul_scheduler.sv
// io_annul_scheduler: barrel-slot I/O annul/retry decision with per-thread
// retry counting, sticky starvation timeout and a global annul statistic.
module io_annul_scheduler #(
  parameter int THREAD_COUNT = 8,
  parameter int THREAD_WIDTH = 3,
  parameter int RETRY_WIDTH  = 8,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    instr_valid,
  input  logic                    IO_ready,
  input  logic [RETRY_WIDTH-1:0]  retry_limit,
  input  logic                    clear_valid,
  input  logic [THREAD_WIDTH-1:0] clear_thread,
  output logic [THREAD_WIDTH-1:0] current_thread,
  output logic                    annul,
  output logic                    io_forced,
  output logic [THREAD_COUNT-1:0] timed_out,
  output logic                    timeout_pulse,
  output logic [THREAD_WIDTH-1:0] timeout_thread,
  output logic [RETRY_WIDTH-1:0]  retry_count,
  output logic [STAT_WIDTH-1:0]   annul_total
);
  logic [RETRY_WIDTH-1:0]  r_retry [THREAD_COUNT];
  logic [THREAD_WIDTH-1:0] r_thread;
  logic [THREAD_COUNT-1:0] r_timed_out;
  logic                    r_pulse;
  logic [THREAD_WIDTH-1:0] r_timeout_thread;
  logic [STAT_WIDTH-1:0]   r_annul_total;
  logic                    w_stalled;
  logic                    w_annul;
  logic                    w_forced;
  logic [RETRY_WIDTH-1:0]  w_retry_cur;
  logic [RETRY_WIDTH:0]    w_retry_inc;
  logic                    w_limit_hit;
  logic                    w_clear_self;
  logic                    w_timeout;
  logic [THREAD_WIDTH-1:0] w_thread_next;
  assign w_stalled     = instr_valid & ~IO_ready;
  assign w_annul       = w_stalled & ~r_timed_out[r_thread];
  assign w_forced      = w_stalled & r_timed_out[r_thread];
  assign w_retry_cur   = r_retry[r_thread];
  // One extra bit so the limit compare is exact even when the counter is saturated
  assign w_retry_inc   = {1'b0, w_retry_cur} + 1'b1;
  assign w_limit_hit   = (|retry_limit) && (w_retry_inc >= {1'b0, retry_limit});
  // A clear aimed at the slot's own thread suppresses the timeout entirely
  assign w_clear_self  = clear_valid && (clear_thread == r_thread);
  assign w_timeout     = w_annul & w_limit_hit & ~w_clear_self;
  assign w_thread_next = (r_thread == THREAD_WIDTH'(THREAD_COUNT - 1)) ? '0 : r_thread + 1'b1;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_thread         <= '0;
      r_timed_out      <= '0;
      r_pulse          <= 1'b0;
      r_timeout_thread <= '0;
      r_annul_total    <= '0;
      for (int i = 0; i < THREAD_COUNT; i++) r_retry[i] <= '0;
    end else begin
      r_thread <= w_thread_next;
      r_pulse  <= w_timeout;
      if (w_annul) r_retry[r_thread] <= (&w_retry_cur) ? w_retry_cur : w_retry_inc[RETRY_WIDTH-1:0];
      else if (instr_valid & IO_ready) r_retry[r_thread] <= '0;
      if (w_timeout) begin
        r_timed_out[r_thread] <= 1'b1;
        r_timeout_thread      <= r_thread;
      end
      // Later assignments win, so a clear overrides this cycle's own-thread update
      if (clear_valid) begin
        r_retry[clear_thread]     <= '0;
        r_timed_out[clear_thread] <= 1'b0;
      end
      if (w_annul && !(&r_annul_total)) r_annul_total <= r_annul_total + 1'b1;
    end
  end
  assign current_thread = r_thread;
  assign annul          = w_annul;
  assign io_forced      = w_forced;
  assign timed_out      = r_timed_out;
  assign timeout_pulse  = r_pulse;
  assign timeout_thread = r_timeout_thread;
  assign retry_count    = w_retry_cur;
  assign annul_total    = r_annul_total;
endmodule
